// File: rtl/stats_pkg.sv
// ----------------------------------------------------------------------------
// stats_pkg
// Shared types for sorted_stream_stats and its median helper.
//   state_t       : frame FSM states (IDLE / COLLECT / REPORT)
//   stats_flags_t : per-result status flags {order_error, short_frame, overrun}
// ----------------------------------------------------------------------------
package stats_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      REPORT  = 2'd2
   } state_t;

   typedef struct packed {
      logic order_error;
      logic short_frame;
      logic overrun;
   } stats_flags_t;

endpackage

// File: rtl/stats_median_calc.sv
// ----------------------------------------------------------------------------
// stats_median_calc
// Combinational median of a frame from its two captured middle elements.
//   n          : latched frame size (0 means "unsized", median is 0)
//   mid_lo     : element (n-1)/2
//   mid_hi     : element n/2
//   median_out : mid_hi for odd n, floor((mid_lo+mid_hi)/2) for even n
// ----------------------------------------------------------------------------
module stats_median_calc #(
   parameter int DATA_WIDTH = 32,
   parameter int CW         = 5
) (
   input  logic [CW-1:0]         n,
   input  logic [DATA_WIDTH-1:0] mid_lo,
   input  logic [DATA_WIDTH-1:0] mid_hi,
   output logic [DATA_WIDTH-1:0] median_out
);

   // One extra bit so the pair sum can never wrap before halving.
   logic [DATA_WIDTH:0] pair_sum;

   assign pair_sum = {1'b0, mid_lo} + {1'b0, mid_hi};

   always_comb begin
      median_out = '0;
      if (n == '0) begin
         median_out = '0;
      end else if (n[0]) begin
         median_out = mid_hi;
      end else begin
         median_out = pair_sum[DATA_WIDTH:1];
      end
   end

endmodule

// File: rtl/sorted_stream_stats.sv
// ----------------------------------------------------------------------------
// sorted_stream_stats
// Collects one frame of a (nominally sorted) unsigned element stream and
// reports min, max, median, element count and status flags, one cycle after
// the last element, holding them until the stats_valid/stats_ready handshake.
//
// Ports
//   clk, reset            : clock (rising edge), asynchronous active-high reset
//   in_valid, in_data     : element stream, one element per cycle
//   frame_size            : expected element count, sampled on the first element
//   stats_valid/ready     : result handshake
//   min_out, max_out      : true extremes of the accepted elements
//   median_out, count_out : median (0 for short or unsized frames), count
//   order_error           : some element was smaller than its predecessor
//   short_frame           : frame ended by a gap before frame_size elements
//   overrun               : element dropped (frame full or during REPORT), sticky
//   busy                  : FSM is in COLLECT or REPORT
//   sum_out               : sum of accepted elements (only with STATS_SUM_EN)
//
// Build option: define STATS_SUM_EN to add the sum accumulator and sum_out.
// ----------------------------------------------------------------------------
module sorted_stream_stats
   import stats_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MAX_COUNT  = 16,
   localparam int CW        = $clog2(MAX_COUNT + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [CW-1:0]         frame_size,
   output logic                  stats_valid,
   input  logic                  stats_ready,
   output logic [DATA_WIDTH-1:0] min_out,
   output logic [DATA_WIDTH-1:0] max_out,
   output logic [DATA_WIDTH-1:0] median_out,
   output logic [CW-1:0]         count_out,
   output logic                  order_error,
   output logic                  short_frame,
   output logic                  overrun,
   output logic                  busy
`ifdef STATS_SUM_EN
   ,
   output logic [DATA_WIDTH+CW-1:0] sum_out
`endif
);

   localparam logic [CW-1:0] MAX_C = CW'(MAX_COUNT);

   state_t                state_reg;
   stats_flags_t          flags_reg;
   logic [CW-1:0]         count_reg;
   logic [CW-1:0]         size_reg;
   logic [DATA_WIDTH-1:0] min_reg;
   logic [DATA_WIDTH-1:0] max_reg;
   logic [DATA_WIDTH-1:0] prev_reg;
   logic [DATA_WIDTH-1:0] mid_lo_reg;
   logic [DATA_WIDTH-1:0] mid_hi_reg;
   logic [DATA_WIDTH-1:0] median_calc;
`ifdef STATS_SUM_EN
   logic [DATA_WIDTH+CW-1:0] sum_reg;
`endif

   logic          accept_first;
   logic          accept_more;
   logic          accept;
   logic          drop;
   logic          gap_end;
   logic          last_elem;
   logic [CW-1:0] elem_idx;
   logic [CW-1:0] n_eff;
   logic [CW-1:0] count_inc;
   logic [CW-1:0] lo_idx;
   logic [CW-1:0] hi_idx;

   // Element bookkeeping. On the first element of a frame the size comes
   // straight from frame_size, since it is only latched at that same edge.
   assign accept_first = (state_reg == IDLE) && in_valid;
   assign accept_more  = (state_reg == COLLECT) && in_valid && (count_reg < MAX_C);
   assign accept       = accept_first || accept_more;
   assign drop         = in_valid && (((state_reg == COLLECT) && (count_reg >= MAX_C)) ||
                                      (state_reg == REPORT));
   assign gap_end      = (state_reg == COLLECT) && !in_valid;
   assign elem_idx     = accept_first ? '0 : count_reg;
   assign n_eff        = accept_first ? frame_size : size_reg;
   assign count_inc    = elem_idx + CW'(1);
   // Going to REPORT on the edge that accepts the N-th element gives the
   // one-cycle result latency.
   assign last_elem    = accept && (n_eff != '0) && (count_inc == n_eff);
   assign lo_idx       = (n_eff - CW'(1)) >> 1;
   assign hi_idx       = n_eff >> 1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= IDLE;
         flags_reg  <= '0;
         count_reg  <= '0;
         size_reg   <= '0;
         min_reg    <= '0;
         max_reg    <= '0;
         prev_reg   <= '0;
         mid_lo_reg <= '0;
         mid_hi_reg <= '0;
`ifdef STATS_SUM_EN
         sum_reg    <= '0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  state_reg <= last_elem ? REPORT : COLLECT;
               end
            end
            COLLECT: begin
               if (last_elem) begin
                  state_reg <= REPORT;
               end else if (gap_end) begin
                  state_reg             <= REPORT;
                  // An unsized frame (N=0) is meant to end on a gap.
                  flags_reg.short_frame <= (size_reg != '0);
               end
            end
            REPORT: begin
               if (stats_ready) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase

         if (drop) begin
            flags_reg.overrun <= 1'b1;
         end

         if (accept) begin
            count_reg <= count_inc;
            prev_reg  <= in_data;
            if (elem_idx == lo_idx) mid_lo_reg <= in_data;
            if (elem_idx == hi_idx) mid_hi_reg <= in_data;
            if (accept_first) begin
               size_reg              <= frame_size;
               min_reg               <= in_data;
               max_reg               <= in_data;
               flags_reg.order_error <= 1'b0;
               flags_reg.short_frame <= 1'b0;
`ifdef STATS_SUM_EN
               sum_reg               <= {{CW{1'b0}}, in_data};
`endif
            end else begin
               // Extremes are tracked fully so out-of-order data still
               // reports the true min and max.
               if (in_data < min_reg)  min_reg <= in_data;
               if (in_data > max_reg)  max_reg <= in_data;
               if (in_data < prev_reg) flags_reg.order_error <= 1'b1;
`ifdef STATS_SUM_EN
               sum_reg               <= sum_reg + {{CW{1'b0}}, in_data};
`endif
            end
         end
      end
   end

   stats_median_calc #(
      .DATA_WIDTH (DATA_WIDTH),
      .CW         (CW)
   ) u_median (
      .n          (size_reg),
      .mid_lo     (mid_lo_reg),
      .mid_hi     (mid_hi_reg),
      .median_out (median_calc)
   );

   assign stats_valid = (state_reg == REPORT);
   assign busy        = (state_reg != IDLE);
   assign min_out     = min_reg;
   assign max_out     = max_reg;
   assign count_out   = count_reg;
   assign median_out  = flags_reg.short_frame ? '0 : median_calc;
   assign order_error = flags_reg.order_error;
   assign short_frame = flags_reg.short_frame;
   assign overrun     = flags_reg.overrun;
`ifdef STATS_SUM_EN
   assign sum_out     = sum_reg;
`endif

endmodule
